// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter.
// Contents: FSM state encoding, the default stall limit and a one-hot to index helper.
package wb_arbiter_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   localparam int unsigned DEFAULT_TIMEOUT = 255;
   localparam int unsigned MAX_MASTERS     = 8;

   // Index of the set bit in a one-hot vector. Returns 0 when no bit is set.
   function automatic logic [2:0] oh_to_idx(input logic [MAX_MASTERS-1:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < int'(MAX_MASTERS); i++) begin
         if (oh[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Wishbone bundle around the arbiter: NUM_MASTERS request slices in, one slave bus out.
// Modports:
//   master  - requester side (drives m_*_i, receives m_dat_o/m_ack_o/m_err_o)
//   slave   - device side (receives s_*_o, drives s_dat_i/s_ack_i/s_err_i)
//   arbiter - the arbiter itself
interface wb_arbiter_if #(
   parameter int unsigned NUM_MASTERS = 2,
   parameter int unsigned AW          = 32,
   parameter int unsigned DW          = 32
);

   logic [NUM_MASTERS-1:0]      m_cyc_i;
   logic [NUM_MASTERS-1:0]      m_stb_i;
   logic [NUM_MASTERS-1:0]      m_we_i;
   logic [4*NUM_MASTERS-1:0]    m_sel_i;
   logic [AW*NUM_MASTERS-1:0]   m_adr_i;
   logic [DW*NUM_MASTERS-1:0]   m_dat_i;
   logic [DW-1:0]               m_dat_o;
   logic [NUM_MASTERS-1:0]      m_ack_o;
   logic [NUM_MASTERS-1:0]      m_err_o;

   logic                        s_cyc_o;
   logic                        s_stb_o;
   logic                        s_we_o;
   logic [3:0]                  s_sel_o;
   logic [AW-1:0]               s_adr_o;
   logic [DW-1:0]               s_dat_o;
   logic [DW-1:0]               s_dat_i;
   logic                        s_ack_i;
   logic                        s_err_i;

   modport master (
      output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
      input  m_dat_o, m_ack_o, m_err_o
   );

   modport slave (
      input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
      output s_dat_i, s_ack_i, s_err_i
   );

   modport arbiter (
      input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
      output m_dat_o, m_ack_o, m_err_o,
      output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
      input  s_dat_i, s_ack_i, s_err_i
   );

endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_i   - request vector
//   ptr_i   - index of the last winner; search starts at ptr_i+1 and wraps
//   gnt_o   - one-hot winner (zero when nothing requests)
//   valid_o - at least one request present
module wb_arbiter_rr_pick #(
   parameter int unsigned N  = 2,
   parameter int unsigned PW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic          valid_o
);

   // Walk the requesters in priority order starting just after the pointer.
   always_comb begin
      int unsigned k;
      gnt_o   = '0;
      valid_o = 1'b0;
      k       = 0;
      for (int unsigned i = 1; i <= N; i++) begin
         k = (32'(ptr_i) + i) % N;
         if (!valid_o && req_i[PW'(k)]) begin
            gnt_o[PW'(k)] = 1'b1;
            valid_o       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone B4 classic arbiter: NUM_MASTERS requesters share one slave bus.
// A grant lasts for the whole bus cycle (cyc high) and one idle cycle separates grants.
// Ports:
//   clk, reset - core clock, synchronous active-high reset
//   bus        - wb_arbiter_if.arbiter (master slices in, slave bus out)
//   grant_o    - registered one-hot grant, zero while idle
// Build option: define WB_ARBITER_TIMEOUT_EN to abort cycles whose strobe stalls for
// TIMEOUT cycles with a one-cycle error pulse to the granted master.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 2,
   parameter int unsigned AW          = 32,
   parameter int unsigned DW          = 32,
   parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT
) (
   input  logic                   clk,
   input  logic                   reset,
   wb_arbiter_if.arbiter          bus,
   output logic [NUM_MASTERS-1:0] grant_o
);

   localparam int unsigned PW = $clog2(NUM_MASTERS);

   arb_state_e             state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [PW-1:0]          ptr_q,   ptr_d;

   logic [NUM_MASTERS-1:0] req_c;
   logic [NUM_MASTERS-1:0] pick_gnt_c;
   logic                   pick_valid_c;
   logic                   granted_cyc_c;
   logic                   timeout_c;

   logic                   s_cyc_c, s_stb_c, s_we_c;
   logic [3:0]             s_sel_c;
   logic [AW-1:0]          s_adr_c;
   logic [DW-1:0]          s_dat_c;

`ifdef WB_ARBITER_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0]          cnt_q,  cnt_d;
   logic [NUM_MASTERS-1:0] mask_q, mask_d;

   // Stale cyc of a timed-out master is ignored for one re-arbitration cycle.
   assign req_c     = bus.m_cyc_i & ~mask_q;
   assign timeout_c = (state_q == ARB_BUSY) && s_stb_c && !bus.s_ack_i && !bus.s_err_i &&
                      (cnt_q == CW'(TIMEOUT - 1));

   // Stall counter: cleared while idle (so every grant starts at 0) and on ack/err.
   always_comb begin
      cnt_d  = cnt_q;
      mask_d = '0;
      if (state_q == ARB_IDLE || bus.s_ack_i || bus.s_err_i) begin
         cnt_d = '0;
      end else if (s_stb_c) begin
         cnt_d = cnt_q + CW'(1);
      end
      if (timeout_c) begin
         cnt_d  = '0;
         mask_d = grant_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         mask_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         mask_q <= mask_d;
      end
   end
`else
   logic unused_timeout;

   assign req_c          = bus.m_cyc_i;
   assign timeout_c      = 1'b0;
   assign unused_timeout = ^32'(TIMEOUT);
`endif

   wb_arbiter_rr_pick #(
      .N  (NUM_MASTERS),
      .PW (PW)
   ) u_rr_pick (
      .req_i   (req_c),
      .ptr_i   (ptr_q),
      .gnt_o   (pick_gnt_c),
      .valid_o (pick_valid_c)
   );

   assign granted_cyc_c = |(bus.m_cyc_i & grant_q);

   // Next-state: arbitrate in IDLE, hold the grant in BUSY until cyc drops (or timeout).
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_valid_c) begin
               state_d = ARB_BUSY;
               grant_d = pick_gnt_c;
            end
         end
         ARB_BUSY: begin
            if (!granted_cyc_c || timeout_c) begin
               state_d = ARB_IDLE;
               grant_d = '0;
               ptr_d   = PW'(oh_to_idx(MAX_MASTERS'(grant_q)));
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         ptr_q   <= PW'(NUM_MASTERS - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   // Slave bus mux: grant_q is zero in IDLE, so the outputs fall to 0 there.
   always_comb begin
      s_cyc_c = 1'b0;
      s_stb_c = 1'b0;
      s_we_c  = 1'b0;
      s_sel_c = '0;
      s_adr_c = '0;
      s_dat_c = '0;
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
         if (grant_q[i]) begin
            s_cyc_c = bus.m_cyc_i[i];
            s_stb_c = bus.m_stb_i[i];
            s_we_c  = bus.m_we_i[i];
            s_sel_c = bus.m_sel_i[4*i +: 4];
            s_adr_c = bus.m_adr_i[AW*i +: AW];
            s_dat_c = bus.m_dat_i[DW*i +: DW];
         end
      end
   end

   assign bus.s_cyc_o = s_cyc_c;
   assign bus.s_stb_o = s_stb_c;
   assign bus.s_we_o  = s_we_c;
   assign bus.s_sel_o = s_sel_c;
   assign bus.s_adr_o = s_adr_c;
   assign bus.s_dat_o = s_dat_c;

   assign bus.m_dat_o = bus.s_dat_i;
   assign bus.m_ack_o = grant_q & {NUM_MASTERS{bus.s_ack_i}};
   assign bus.m_err_o = grant_q & {NUM_MASTERS{bus.s_err_i | timeout_c}};
   assign grant_o     = grant_q;

endmodule
